// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl: 16x16 unsigned multiply sequenced over one shared 8x8 multiplier in four cycles.
module mult16_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] p,
  output logic [7:0]  mul_m,
  output logic [7:0]  mul_q,
  input  logic [15:0] mul_c
);
  typedef enum logic [2:0] {IDLE, LL, LH, HL, HH, DONE} state_t;
  state_t state;
  logic [15:0] ra, rb;
  logic [31:0] acc;
  assign p = acc;
  // Multiplier bytes are registered one state ahead so they never depend on start/a/b combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mul_m <= '0;
      mul_q <= '0;
    end else begin
      case (state)
        LL: begin
          acc   <= acc + {16'b0, mul_c};
          state <= LH;
          mul_m <= ra[7:0];
          mul_q <= rb[15:8];
        end
        LH: begin
          acc   <= acc + {8'b0, mul_c, 8'b0};
          state <= HL;
          mul_m <= ra[15:8];
          mul_q <= rb[7:0];
        end
        HL: begin
          acc   <= acc + {8'b0, mul_c, 8'b0};
          state <= HH;
          mul_m <= ra[15:8];
          mul_q <= rb[15:8];
        end
        HH: begin
          acc   <= acc + {mul_c, 16'b0};
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          mul_m <= '0;
          mul_q <= '0;
        end
        default: begin
          done  <= 1'b0;
          busy  <= start;
          state <= start ? LL : IDLE;
          mul_m <= start ? a[7:0] : 8'h00;
          mul_q <= start ? b[7:0] : 8'h00;
          if (start) begin
            ra  <= a;
            rb  <= b;
            acc <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb_mult16_seq_ctrl: scoreboard bench for the sequenced 16x16 multiplier with a behavioural 8x8 multiplier.
module tb_mult16_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] p;
  logic [7:0]  mul_m, mul_q;
  logic [15:0] mul_c;
  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  assign mul_c = 16'(mul_m) * 16'(mul_q);

  mult16_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p), .mul_m(mul_m), .mul_q(mul_q), .mul_c(mul_c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done p=%h", p);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (p !== e) begin
          failures++;
          $display("FAIL sb_product got=%h exp=%h", p, e);
        end
      end
    end
  end

  task automatic do_mult(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (!done && n < 20) begin
      if (busy) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4 || !done) begin
      failures++;
      $display("FAIL mult_busy_cycles got=%0d done=%b exp=4", n, done);
    end
    checks++;
    if (p !== exp) begin
      failures++;
      $display("FAIL mult_p got=%h exp=%h", p, exp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== exp) begin
      failures++;
      $display("FAIL mult_after busy=%b done=%b p=%h exp 0 0 %h", busy, done, p, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, p, mul_m, mul_q} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b p=%h m=%h q=%h exp all 0", busy, done, p, mul_m, mul_q);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, p} !== '0) begin
      failures++;
      $display("FAIL reset_release busy=%b done=%b p=%h exp 0", busy, done, p);
    end
  endtask

  task automatic test_products();
    do_mult(16'h0001, 16'h0002, 32'h00000002);
    do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    do_mult(16'h1234, 16'h5678, 32'h06260060);
  endtask

  task automatic test_mux_sequence();
    logic [7:0] em[4];
    logic [7:0] eq[4];
    em = '{8'h12, 8'h12, 8'hAB, 8'hAB};
    eq = '{8'h34, 8'hCD, 8'h34, 8'hCD};
    @(negedge clk);
    checks++;
    if (mul_m !== 8'h00 || mul_q !== 8'h00) begin
      failures++;
      $display("FAIL mux_idle m=%h q=%h exp 00 00", mul_m, mul_q);
    end
    start = 1'b1; a = 16'hAB12; b = 16'hCD34;
    sb.push_back(32'hAB12 * 32'hCD34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (mul_m !== em[i] || mul_q !== eq[i]) begin
        failures++;
        $display("FAIL mux_step%0d m=%h q=%h exp %h %h", i, mul_m, mul_q, em[i], eq[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (!done || mul_m !== 8'h00 || mul_q !== 8'h00) begin
      failures++;
      $display("FAIL mux_done done=%b m=%h q=%h exp 1 00 00", done, mul_m, mul_q);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    int dn;
    @(negedge clk);
    start = 1'b1; a = 16'd3; b = 16'd5;
    sb.push_back(32'h0000000F);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'd7; b = 16'd7;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 1 || p !== 32'h0000000F) begin
      failures++;
      $display("FAIL busy_start dones=%0d p=%h exp 1 0000000f", dn, p);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; a = 16'h0100; b = 16'h0100;
    sb.push_back(32'h00010000);
    @(negedge clk);
    sb.push_back(32'h00000006);
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (!done || p !== 32'h00010000) begin
      failures++;
      $display("FAIL b2b_first done=%b p=%h exp 1 00010000", done, p);
    end
    a = 16'd2; b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!busy || done || p !== 32'h0) begin
      failures++;
      $display("FAIL b2b_restart busy=%b done=%b p=%h exp 1 0 0", busy, done, p);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!done || p !== 32'h00000006) begin
      failures++;
      $display("FAIL b2b_second done=%b p=%h exp 1 00000006", done, p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dn;
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, p, mul_m, mul_q} !== '0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b p=%h m=%h q=%h exp all 0", busy, done, p, mul_m, mul_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn != 0 || p !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_nodone dones=%0d p=%h exp 0 0", dn, p);
    end
    do_mult(16'h00FF, 16'h0101, 32'h0000FFFF);
  endtask

  initial begin
    test_reset();
    test_products();
    test_mux_sequence();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
